// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and FSM encoding for the iterative multiplier.
//   MUL_W       default operand width
//   MUL_CNT_W   default iteration counter width
//   mul_state_t IDLE / RUN / FIX
package mul_pkg;
  localparam int MUL_W     = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mul_state_t;
endpackage

// File: rtl/mul_seq_cla.sv
// Carry-lookahead adder built from 4-bit PG/GG slices.
//   cla4       one 4-bit slice: sum plus group propagate/generate
//     x, y, ci -> s, pg, gg
//   cla_add33  W-bit add with carry out (W+1-bit result) from W/4 slices and a
//              second-level lookahead over the slice pg/gg pairs
//     x, y, ci -> s[W:0] (s[W] is the carry out)
module cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p, g, c;

  assign p = x ^ y;
  assign g = x & y;

  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < 3; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s  = p ^ c;
  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla_add33 import mul_pkg::*; #(
  parameter int W = MUL_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W:0]   s
);
  localparam int NS = W / 4;

  logic [NS-1:0]      pg, gg;
  logic [NS:0]        c;
  logic [NS-1:0][3:0] s4;

  // Slice carries come only from group pg/gg, never from slice sums.
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < NS; i++) c[i+1] = gg[i] | (pg[i] & c[i]);
  end

  generate
    for (genvar i = 0; i < NS; i++) begin : g_sl
      cla4 u_sl (
        .x  (x[4*i +: 4]),
        .y  (y[4*i +: 4]),
        .ci (c[i]),
        .s  (s4[i]),
        .pg (pg[i]),
        .gg (gg[i])
      );
    end
  endgenerate

  assign s = {c[NS], s4};
endmodule

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier for MULT/MULTU, owns HI/LO.
//   clk, rst_n            clock, async active-low reset
//   start, signed_op,a,b  launch a multiply (accepted only when idle)
//   cancel                abort an op in flight (no result, no done)
//   hi_we, lo_we, wdata   MTHI/MTLO writes, honoured only when idle
//   busy                  op in flight
//   done                  one-cycle pulse, hi/lo hold the new product
//   hi, lo                product registers
// Optional: define MUL_EARLY_TERM_EN to leave RUN as soon as the remaining
// multiplier bits are all zero; FIX then right-aligns the partial product.
module mul_seq import mul_pkg::*; #(
  parameter int W  = MUL_W,
  parameter int CW = MUL_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cancel,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  mul_state_t     state;
  logic [W-1:0]   acc, mq, mcand;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic [W-1:0]   a_abs, b_abs, fhi, flo, ax, ay, nmq;
  logic           ac, fin, hi_co_unused;
  logic [W:0]     as, hs;
  logic [2*W-1:0] res;

  // Magnitudes; -0x80000000 wraps back to 0x80000000, which is the correct
  // unsigned magnitude.
  assign a_abs = (signed_op && a[W-1]) ? -a : a;
  assign b_abs = (signed_op && b[W-1]) ? -b : b;

`ifdef MUL_EARLY_TERM_EN
  // Set bits mark mq positions still holding unconsumed multiplier bits.
  logic [W-1:0] rem, rem_n;
  assign rem_n = rem >> 1;
  // cnt counts the steps skipped, so shift the product down by that much.
  assign {fhi, flo} = {acc, mq} >> cnt;
  assign fin = ((nmq & rem_n) == '0) || (cnt == CW'(1));
`else
  assign {fhi, flo} = {acc, mq};
  assign fin = (cnt == CW'(1));
`endif

  // Low adder is shared: RUN does acc + partial, FIX does ~lo + 1.
  always_comb begin
    if (state == FIX) begin
      ax = ~flo;
      ay = '0;
      ac = 1'b1;
    end else begin
      ax = acc;
      ay = mq[0] ? mcand : '0;
      ac = 1'b0;
    end
  end

  cla_add33 #(.W(W)) u_lo (.x(ax), .y(ay), .ci(ac), .s(as));
  // High half of the negation takes the low half's carry in the same cycle.
  cla_add33 #(.W(W)) u_hi (.x(~fhi), .y({W{1'b0}}), .ci(as[W]), .s(hs));

  assign hi_co_unused = hs[W];
  assign res = neg ? {hs[W-1:0], as[W-1:0]} : {fhi, flo};
  assign nmq = {as[0], mq[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
`ifdef MUL_EARLY_TERM_EN
      rem   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          // A start during the done pulse is dropped, as is one with cancel.
          if (start && !cancel && !done) begin
            mcand <= a_abs;
            mq    <= b_abs;
            neg   <= signed_op & (a[W-1] ^ b[W-1]);
            acc   <= '0;
            cnt   <= CW'(W);
            busy  <= 1'b1;
            state <= RUN;
`ifdef MUL_EARLY_TERM_EN
            rem   <= '1;
`endif
          end
        end
        RUN: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= as[W:1];
            mq  <= nmq;
            cnt <= cnt - CW'(1);
`ifdef MUL_EARLY_TERM_EN
            rem <= rem_n;
`endif
            if (fin) state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!cancel) begin
            hi   <= res[2*W-1:W];
            lo   <= res[W-1:0];
            done <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vectors for mul_seq. A transaction-level model (64-bit
// products, latency formula) is compared every cycle; hand-computed literals
// pin products and latencies.
module tb_mul_seq;
  localparam int W = 32;
`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic         clk = 0, rst_n = 0, start = 0, signed_op = 0, cancel = 0;
  logic         hi_we = 0, lo_we = 0;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 0;

  mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (s) return sx * sy;
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic int lat_of(input logic [31:0] y, input logic s);
    logic [31:0] m;
    int n;
    m = (s && y[31]) ? -y : y;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return ET ? 2 + n : 34;
  endfunction

  // Reference model: start-to-done latency and full-width product.
  logic         m_busy = 0, m_done = 0;
  logic [W-1:0] m_hi = 0, m_lo = 0;
  logic [63:0]  m_res = 0;
  int           m_left = 0;

  always @(posedge clk or negedge rst_n) begin : mdl
    logic nd;
    nd = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; m_left = 0;
    end else begin
      if (m_busy) begin
        if (cancel) m_busy = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = m_res[63:32]; m_lo = m_res[31:0]; m_busy = 0; nd = 1'b1;
          end
        end
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start && !cancel && !m_done) begin
          m_busy = 1;
          m_left = lat_of(b, signed_op) - 1;
          m_res  = prod(a, b, signed_op);
        end
      end
      m_done = nd;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("busy_done_excl", busy & done, 1'b0);
    end
  end

  task automatic go(input logic [31:0] x, input logic [31:0] y, input logic s, output int t0);
    @(posedge clk); #1;
    a = x; b = y; signed_op = s; start = 1; t0 = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin lat = cyc - t0; break; end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within 80 cycles");
    end
  endtask

  task automatic mul_case(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [31:0] eh, input logic [31:0] el,
                          input int lat_def, input int lat_et);
    int t0, lat;
    go(x, y, s, t0);
    wait_done(t0, lat);
    check({name, "_lat"}, lat, ET ? lat_et : lat_def);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, lat;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst_n = 1; chk_en = 1;

    mul_case("u3x5",   32'd3,        32'd5,        0, 32'h0,        32'hF,        34, 5);
    mul_case("uffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h1,        34, 34);
    mul_case("s80x80", 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h0,        34, 34);
    mul_case("sm1x7",  32'hFFFFFFFF, 32'd7,        1, 32'hFFFFFFFF, 32'hFFFFFFF9, 34, 5);
    mul_case("s7xm3",  32'd7,        32'hFFFFFFFD, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 4);
    mul_case("sm6xm5", 32'hFFFFFFFA, 32'hFFFFFFFB, 1, 32'h0,        32'h1E,       34, 5);
    mul_case("sm5x0",  32'hFFFFFFFB, 32'd0,        1, 32'h0,        32'h0,        34, 3);
    mul_case("u7x1",   32'd7,        32'd1,        0, 32'h0,        32'h7,        34, 3);

    // start during the done pulse is dropped
    a = 32'd9; b = 32'd9; signed_op = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    check("start_on_done_busy", busy, 0);
    check("start_on_done_lo", lo, 32'h7);

    // start while busy is dropped
    go(32'd3, 32'd5, 0, t0);
    repeat (2) @(posedge clk);
    #1;
    a = 32'd9; b = 32'd9; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(t0, lat);
    check("start_busy_lat", lat, ET ? 5 : 34);
    check("start_busy_lo", lo, 32'hF);

    // register write together with start: write lands, result overwrites
    @(posedge clk); #1;
    hi_we = 1; lo_we = 1; wdata = 32'h55; a = 32'd3; b = 32'd5; signed_op = 0; start = 1; t0 = cyc;
    @(posedge clk); #1;
    hi_we = 0; lo_we = 0; start = 0;
    check("we_start_hi", hi, 32'h55);
    check("we_start_lo", lo, 32'h55);
    wait_done(t0, lat);
    check("we_start_res_hi", hi, 32'h0);
    check("we_start_res_lo", lo, 32'hF);

    // MTHI/MTLO, then cancel mid-op; writes while busy are ignored
    @(posedge clk); #1;
    hi_we = 1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 0; lo_we = 1; wdata = 32'h0;
    @(posedge clk); #1;
    lo_we = 0; a = 32'd2; b = ET ? 32'h80000000 : 32'd2; signed_op = 0; start = 1; t0 = cyc;
    seen = 0; t1 = 0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      start  = 0;
      hi_we  = (k == 5);
      wdata  = (k == 5) ? 32'hDEAD : 32'h0;
      cancel = (k == 10);
      if (k == 11) begin a = 32'd2; b = 32'd2; start = 1; t1 = cyc; end
      if (done) seen = 1;
    end
    check("cancel_no_done", seen, 0);
    check("cancel_hi", hi, 32'h1234);
    check("cancel_lo", lo, 32'h0);
    check("cancel_t0_gap", t1 - t0, 11);
    @(posedge clk); #1;
    start = 0;
    wait_done(t1, lat);
    check("after_cancel_lat", lat, ET ? 4 : 34);
    check("after_cancel_hi", hi, 32'h0);
    check("after_cancel_lo", lo, 32'h4);

    // async reset mid-RUN clears everything at once
    go(32'hFFFFFFFF, 32'hFFFFFFFF, 0, t0);
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    #1 rst_n = 1;
    mul_case("post_rst", 32'd3, 32'd5, 0, 32'h0, 32'hF, 34, 5);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
